// File: rtl/conv_line_ctrl.sv
// Frame sequencer for the line-buffered convolution stage: walks a raster-scan
// pixel stream, drives line-buffer enables/addresses and re-times window-valid flags.
module conv_line_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int FN       = 3,
  parameter int ADDR_W   = 11,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              lb_wen,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic              lb_ren,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              out_valid,
  output logic              out_last,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_WIN  = ADDR_W'(FN - 1);
  localparam logic [ROW_W-1:0]  ROW_WIN  = ROW_W'(FN - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PIPE_LAT - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   col;
  logic [ROW_W-1:0]    row;
  logic [CNT_W-1:0]    cnt;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [PIPE_LAT-1:0] last_sr;

  logic accept;
  logic col_end;
  logic row_end;
  logic last_px;
  logic win;

  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);
  assign last_px = col_end && row_end;
  // Window position is judged on the pre-increment coordinates of the accepted pixel.
  assign win     = (row >= ROW_WIN) && (col >= COL_WIN);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start)              state_n = S_RUN;
      S_RUN:   if (accept && last_px)  state_n = S_FLUSH;
      S_FLUSH: if (cnt == '0)          state_n = S_DONE;
      S_DONE:                          state_n = S_IDLE;
      default:                         state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = (state == S_RUN);
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    accept     = in_valid && in_ready;
    lb_wen     = accept;
    lb_ren     = accept;
    lb_waddr   = col;
    lb_raddr   = col;
    out_valid  = vld_sr[PIPE_LAT-1];
    out_last   = last_sr[PIPE_LAT-1];
  end

  // ---------------------------------------------------------------------------
  // Raster position
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (abort || (state == S_IDLE)) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flush countdown: covers the filter latency after the last pixel
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (accept && last_px) begin
      cnt <= CNT_LOAD;
    end else if ((state == S_FLUSH) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid/last re-timing pipeline, free-running so stalls still drain it
  // ---------------------------------------------------------------------------
  // NOTE: this shift register is reset explicitly; stale flags would otherwise
  // emit spurious out_valid pulses after power-up or abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else if (abort) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= accept && win;
      last_sr[0] <= accept && win && last_px;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

endmodule

// File: doc/conv_line_ctrl.md
# conv_line_ctrl

Frame sequencer for the line-buffered convolution stage. It accepts a raster-scan pixel stream and drives the line-buffer write/read enables and addresses. It tracks row and column position and flags which pixels complete a valid FN×FN window. It then re-times that flag through the filter pipeline latency to give an output-valid strobe, a last-output marker and a frame-done pulse. It sits between the upstream pixel source and the line-buffer/filter datapath; one instance serves all input channels of a layer.

## Interface
- IMG_W, 28, pixels per line (2..2^ADDR_W)
- IMG_H, 28, lines per frame (2..2047)
- FN, 3, filter window size (2..IMG_W, ≤IMG_H)
- ADDR_W, 11, line-buffer address width
- PIPE_LAT, 2, cycles from pixel acceptance to filter output (≥1)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  begin frame (honoured only in IDLE)
- abort  in  1  synchronous cancel, any state
- in_valid  in  1  upstream pixel present
- in_ready  out  1  controller accepts pixel
- lb_wen  out  1  line-buffer write enable
- lb_waddr  out  ADDR_W  line-buffer write address
- lb_ren  out  1  line-buffer read enable
- lb_raddr  out  ADDR_W  line-buffer read address
- out_valid  out  1  filter output is a valid window result
- out_last  out  1  final valid output of frame
- frame_done  out  1  one-cycle end-of-frame pulse
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start goes to RUN. col and row clear to 0.
- RUN: in_ready=1. accept = in_valid & in_ready.
- On accept:
  - col increments; at col=IMG_W-1 it wraps to 0 and row increments.
  - When row=IMG_H-1 and col=IMG_W-1 is accepted, go to FLUSH with a PIPE_LAT-cycle countdown.
- FLUSH: in_ready=0. Stay PIPE_LAT cycles, then go to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Line-buffer drive is combinational from accept and registered col:
  - lb_wen = lb_ren = accept
  - lb_waddr = lb_raddr = col, zero-extended to ADDR_W
- The line buffer has read-before-write semantics at the same address, so a read returns the previous line's pixel.
- The window is complete for an accepted pixel at (row, col) when row ≥ FN-1 and col ≥ FN-1.
- A PIPE_LAT-deep shift register carries the window-complete flag and a last flag to produce out_valid and out_last. The last flag is window-complete on pixel (IMG_H-1, IMG_W-1).
- Valid outputs per frame: (IMG_H-FN+1)·(IMG_W-FN+1).
- abort, in any state: next cycle IDLE. Clears col, row, countdown and the valid shift register. No frame_done is produced.
- abort and start in the same cycle: abort wins and the state stays IDLE.
- start outside IDLE is ignored.
- in_valid outside RUN is ignored: no counter movement, lb_wen=0.
- Stalls (in_valid=0 in RUN) freeze col/row. Valid-flag shifting continues every cycle because the pipeline is free-running.

## Timing
- Reset values: state IDLE, col/row/countdown 0, shift register 0. Outputs: in_ready 0, lb_wen 0, lb_ren 0, lb_waddr 0, lb_raddr 0, out_valid 0, out_last 0, frame_done 0, busy 0.
- start sampled at cycle t: RUN and in_ready=1 at t+1.
- Pixel accepted at cycle a: its out_valid/out_last appear at a+PIPE_LAT.
- Last pixel accepted at cycle L:
  - FLUSH during L+1..L+PIPE_LAT
  - out_last at L+PIPE_LAT
  - frame_done at L+PIPE_LAT+1
  - IDLE and busy=0 at L+PIPE_LAT+2
- Back-to-back frames: start is accepted at the earliest in the IDLE cycle, so the minimum inter-frame gap is PIPE_LAT+2 cycles.
- col wrap and row increment take effect in the same edge as the accept of the line's last pixel. The first pixel of the next line writes address 0.
- Asynchronous resetn assertion mid-frame: all registers return to reset values immediately. Outputs follow in the same cycle.

## Test plan
- IMG_W=IMG_H=8, FN=3, PIPE_LAT=2; start, then in_valid held high for 64 cycles:
  - exactly 36 out_valid, in 6 bursts of 6
  - first out_valid 2 cycles after accepting pixel (2,2)
  - out_last coincident with the 36th out_valid
  - frame_done 3 cycles after the 64th accept
- Same frame with in_valid toggled pseudo-randomly:
  - 36 out_valid
  - lb_waddr sequence 0..7 repeated 8 times
  - no counter motion on idle cycles
- abort asserted after 30 accepts:
  - IDLE next cycle
  - no further out_valid beyond those already due… none after abort edge
  - no frame_done
  - a fresh start then yields a full 36-output frame
- start and abort together in IDLE → stays IDLE, busy=0. start pulsed during RUN → no effect on counters.
- resetn dropped mid-RUN (row=4, col=5) → all outputs 0 asynchronously. After release the controller is in IDLE and in_ready=0.
- IMG_W=5, IMG_H=3, FN=3, PIPE_LAT=1:
  - 3 out_valid, for pixels (2,2), (2,3), (2,4)
  - out_last on the third
  - frame_done 2 cycles after the final accept
